merge_tree_param: RTL and testbench
===================================

Name: merge_tree_param

Overview:
- Parametrised successor of the fixed-size 128-leaf merger tree.
- Merges LEAVES sorted input streams into one sorted stream through a binary tree of 2-to-1 merge nodes, one record per cycle, with a DEPTH-entry buffer between levels.
- Adds what the fixed tree lacks: arbitrary power-of-two leaf count, configurable buffer depth, asynchronous reset, and run termination (last flag) so back-to-back runs merge without a flush.
- Sits between the leaf input FIFOs and the output FIFO.

Parameters:
- LEAVES, 8, number of input streams; power of two, 2..256.
- DATA_WIDTH, 32, record width; records compare as unsigned.
- DEPTH, 4, entries per inter-level buffer; power of two, minimum 2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_fifo  in  DATA_WIDTH*LEAVES  head records, show-ahead; leaf k at bits [DATA_WIDTH*k +: DATA_WIDTH].
- i_fifo_empty  in  LEAVES  leaf k head is invalid.
- i_fifo_last  in  LEAVES  leaf k head is the final record of its run.
- o_fifo_read  out  LEAVES  pop leaf k this cycle; combinational.
- i_fifo_out_ready  in  1  downstream can accept a record next edge.
- o_out_fifo_write  out  1  o_data valid; registered.
- o_data  out  DATA_WIDTH  merged record; registered.
- o_last  out  1  o_data is the final record of the merged run; registered.

Behaviour:
- Tree: log2(LEAVES) levels. Every non-root node feeds a DEPTH-entry FIFO. The root drives the output registers.
- FIFO timing: write at the clock edge, visible (not empty) the next cycle. Each entry stores {last, data}.
- Per-node states:
  - MERGE: fire only when both heads are valid. Pick the smaller record; on a tie pick input A (lower index). If the picked record has last=1, go to DRAIN_B (A was picked) or DRAIN_A (B was picked).
  - DRAIN_A / DRAIN_B: forward only the remaining side while its head is valid. When its last record is forwarded, return to MERGE.
- Output last flag: set only on the record that completes both input runs, i.e. the one forwarded in the DRAIN state. A record that ends the first of the two runs is forwarded with last=0.
- Fire condition: required head(s) valid AND out_ready. Non-root out_ready = ~full | parent_read, so a full FIFO popped this cycle accepts a write. Root out_ready = i_fifo_out_ready.
- On fire: assert read on exactly the consumed input in the same cycle, and write one record.
- No fire: no reads, no writes, state held.
- Root output: registered. o_out_fifo_write=1 for exactly one cycle per fire.
- Latency: leaf heads valid at cycle 0 with no stalls gives o_out_fifo_write at cycle log2(LEAVES). Throughput is 1 record/cycle when no stalls occur.
- Empty leaf mid-run in MERGE: node stalls. It must not forward the other side.
- Full FIFO: parent reading it in the same cycle allows the write; otherwise the child stalls with no read.
- Reset (async, any time, including mid-run):
  - All FIFOs empty, pointers 0.
  - All nodes in MERGE.
  - o_out_fifo_write=0, o_data=0, o_last=0.
  - o_fifo_read=0 while i_rst_n=0.
  - In-flight records are discarded.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and the rest are equal.

Optional Feature:
- Macro: MERGE_TREE_DESCENDING_EN.
- Defined: nodes pick the larger record; ties still go to input A; output is descending.
- Undefined: ascending as above.
- Ports and timing are identical in both cases.

Test Plan:
- LEAVES=4, DEPTH=4, ready=1; leaves {1,5},{2,6},{3,7},{4,8}, last on 5,6,7,8 -> output 1..8 on consecutive cycles, first write at cycle 2, o_last=1 only with 8.
- Ties: leaves 0 and 1 both present 9 (LEAVES=2), last on each -> leaf 0 is popped first, output 9,9, o_last on the second only.
- Back-pressure: i_fifo_out_ready=0 for 10 cycles mid-stream -> no writes during the stall, internal FIFOs fill to 4 and hold, no leaf over-read, output order intact after release.
- Back-to-back runs: leaf 0 {2(last),1(last)}, leaf 1 {3(last),0(last)} -> output 2,3(last),0,1(last).
- Async reset after 3 outputs of a 16-record run -> outputs clear immediately, no o_fifo_read during reset, a fresh run {10},{11} after release yields 10,11(last).
- With MERGE_TREE_DESCENDING_EN, leaves {8,4},{7,3} (descending) -> output 8,7,4,3(last).

Source files
------------

// File: rtl/merge_tree_param.sv
// merge_tree_param: merges LEAVES sorted leaf streams into one sorted stream.
// A binary tree of 2-to-1 merge nodes (heap indexed: root = 1, children of
// n are 2n / 2n+1, leaf k = node LEAVES+k) with a DEPTH-entry {last, data}
// FIFO behind every non-root node. One record per cycle, runs end on last.
// Optional macro MERGE_TREE_DESCENDING_EN: nodes pick the larger record.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_fifo             leaf head records, leaf k at [DATA_WIDTH*k +: DATA_WIDTH]
//   i_fifo_empty       leaf head invalid
//   i_fifo_last        leaf head ends its run
//   o_fifo_read        leaf pop strobes (combinational)
//   i_fifo_out_ready   downstream accepts a record
//   o_out_fifo_write   o_data/o_last valid (registered)
//   o_data, o_last     merged record and end-of-merged-run flag (registered)
module merge_tree_param #(
    parameter int unsigned LEAVES     = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [DATA_WIDTH*LEAVES-1:0] i_fifo,
    input  logic [LEAVES-1:0]            i_fifo_empty,
    input  logic [LEAVES-1:0]            i_fifo_last,
    output logic [LEAVES-1:0]            o_fifo_read,
    input  logic                         i_fifo_out_ready,
    output logic                         o_out_fifo_write,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_last
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned NODES = 2 * LEAVES;
    localparam int unsigned EW    = DATA_WIDTH + 1;

    typedef enum logic [1:0] {MERGE, DRAIN_A, DRAIN_B} node_state_t;

    // Per source (leaf or inter-level FIFO) head view and pop strobe
    logic [NODES-1:0]      src_valid;
    logic [NODES-1:0]      src_last;
    logic [NODES-1:0]      src_read;
    logic [DATA_WIDTH-1:0] src_data [NODES];
    logic [NODES-1:0]      fifo_full;

    // Per merge node state and combinational decision
    node_state_t           state_q  [LEAVES];
    logic [PW-1:0]         wptr_q   [LEAVES];
    logic [PW-1:0]         rptr_q   [LEAVES];
    logic [EW-1:0]         mem_q    [LEAVES][DEPTH];
    logic [LEAVES-1:0]     node_rdy;
    logic [LEAVES-1:0]     node_pick_a;
    logic [LEAVES-1:0]     node_sel_a;
    logic [LEAVES-1:0]     node_fire;
    logic [LEAVES-1:0]     node_plast;
    logic [LEAVES-1:0]     node_wlast;
    logic [DATA_WIDTH-1:0] node_data [LEAVES];

    // Source heads: leaves come straight from the ports, others from FIFOs
    always_comb begin
        src_valid = '0;
        src_last  = '0;
        fifo_full = '0;
        for (int unsigned n = 0; n < NODES; n++) begin
            src_data[n] = '0;
        end
        for (int unsigned k = 0; k < LEAVES; k++) begin
            src_valid[LEAVES+k] = ~i_fifo_empty[k];
            src_last[LEAVES+k]  = i_fifo_last[k];
            src_data[LEAVES+k]  = i_fifo[DATA_WIDTH*k +: DATA_WIDTH];
        end
        for (int unsigned n = 2; n < LEAVES; n++) begin
            src_valid[n] = (wptr_q[n] != rptr_q[n]);
            {src_last[n], src_data[n]} = mem_q[n][rptr_q[n][AW-1:0]];
            fifo_full[n] = (wptr_q[n][AW] != rptr_q[n][AW]) &&
                           (wptr_q[n][AW-1:0] == rptr_q[n][AW-1:0]);
        end
    end

    // Node decisions, root first so each node sees its parent's pop of its FIFO
    always_comb begin
        src_read    = '0;
        node_rdy    = '0;
        node_pick_a = '0;
        node_sel_a  = '0;
        node_fire   = '0;
        node_plast  = '0;
        node_wlast  = '0;
        for (int unsigned n = 0; n < LEAVES; n++) begin
            node_data[n] = '0;
        end
        for (int unsigned n = 1; n < LEAVES; n++) begin
            node_rdy[n] = (n == 1) ? i_fifo_out_ready
                                   : (~fifo_full[n] | src_read[n]);
`ifdef MERGE_TREE_DESCENDING_EN
            node_pick_a[n] = (src_data[2*n] >= src_data[2*n+1]);
`else
            node_pick_a[n] = (src_data[2*n] <= src_data[2*n+1]);
`endif
            case (state_q[n])
                DRAIN_A: begin
                    node_sel_a[n] = 1'b1;
                    node_fire[n]  = src_valid[2*n] & node_rdy[n];
                end
                DRAIN_B: begin
                    node_sel_a[n] = 1'b0;
                    node_fire[n]  = src_valid[2*n+1] & node_rdy[n];
                end
                default: begin
                    node_sel_a[n] = node_pick_a[n];
                    node_fire[n]  = src_valid[2*n] & src_valid[2*n+1] & node_rdy[n];
                end
            endcase
            node_plast[n] = node_sel_a[n] ? src_last[2*n] : src_last[2*n+1];
            node_data[n]  = node_sel_a[n] ? src_data[2*n] : src_data[2*n+1];
            // Only the record that closes the second run carries last onward
            node_wlast[n] = (state_q[n] != MERGE) & node_plast[n];
            src_read[2*n]   = node_fire[n] & node_sel_a[n];
            src_read[2*n+1] = node_fire[n] & ~node_sel_a[n];
        end
    end

    assign o_fifo_read = src_read[NODES-1:LEAVES] & {LEAVES{i_rst_n}};

    // Node states, FIFO pointers and root output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_fifo_write <= 1'b0;
            o_data           <= '0;
            o_last           <= 1'b0;
            for (int unsigned n = 0; n < LEAVES; n++) begin
                state_q[n] <= MERGE;
                wptr_q[n]  <= '0;
                rptr_q[n]  <= '0;
            end
        end else begin
            o_out_fifo_write <= node_fire[1];
            if (node_fire[1]) begin
                o_data <= node_data[1];
                o_last <= node_wlast[1];
            end
            for (int unsigned n = 1; n < LEAVES; n++) begin
                if (node_fire[n] && node_plast[n]) begin
                    if (state_q[n] == MERGE) begin
                        state_q[n] <= node_sel_a[n] ? DRAIN_B : DRAIN_A;
                    end else begin
                        state_q[n] <= MERGE;
                    end
                end
            end
            for (int unsigned n = 2; n < LEAVES; n++) begin
                if (node_fire[n]) begin
                    wptr_q[n] <= wptr_q[n] + PW'(1);
                end
                if (src_read[n]) begin
                    rptr_q[n] <= rptr_q[n] + PW'(1);
                end
            end
        end
    end

    // FIFO storage, no reset needed: pointers define occupancy
    always_ff @(posedge i_clk) begin
        for (int unsigned n = 2; n < LEAVES; n++) begin
            if (node_fire[n]) begin
                mem_q[n][wptr_q[n][AW-1:0]] <= {node_wlast[n], node_data[n]};
            end
        end
    end

endmodule

// File: tb/tb_merge_tree_param.sv
// Directed bench for merge_tree_param: a 4-leaf and a 2-leaf instance share
// clock, reset and downstream ready; leaves are modelled as show-ahead queues.
module tb_merge_tree_param;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ready;
    logic [4*DW-1:0] fifo4;
    logic [3:0]      empty4, last4, rd4, p4;
    logic            wr4, l4;
    logic [DW-1:0]   d4;
    logic [2*DW-1:0] fifo2;
    logic [1:0]      empty2, last2, rd2, p2;
    logic            wr2, l2;
    logic [DW-1:0]   d2;

    merge_tree_param #(.LEAVES(4), .DATA_WIDTH(DW), .DEPTH(4)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_fifo(fifo4), .i_fifo_empty(empty4),
        .i_fifo_last(last4), .o_fifo_read(rd4), .i_fifo_out_ready(ready),
        .o_out_fifo_write(wr4), .o_data(d4), .o_last(l4));

    merge_tree_param #(.LEAVES(2), .DATA_WIDTH(DW), .DEPTH(4)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_fifo(fifo2), .i_fifo_empty(empty2),
        .i_fifo_last(last2), .o_fifo_read(rd2), .i_fifo_out_ready(ready),
        .o_out_fifo_write(wr2), .o_data(d2), .o_last(l2));

    logic [DW:0] q4 [4][$];
    logic [DW:0] q2 [2][$];
    int out4_d[$], out4_l[$], out4_c[$];
    int out2_d[$], out2_l[$];
    int pop_order2[$];
    int popcnt4[4];
    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    // Present queue heads to both instances
    task automatic drive();
        logic [DW:0] h;
        for (int k = 0; k < 4; k++) begin
            if (q4[k].size() != 0) begin
                h = q4[k][0];
                fifo4[DW*k +: DW] = h[DW-1:0]; last4[k] = h[DW]; empty4[k] = 1'b0;
            end else begin
                fifo4[DW*k +: DW] = '0; last4[k] = 1'b0; empty4[k] = 1'b1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (q2[k].size() != 0) begin
                h = q2[k][0];
                fifo2[DW*k +: DW] = h[DW-1:0]; last2[k] = h[DW]; empty2[k] = 1'b0;
            end else begin
                fifo2[DW*k +: DW] = '0; last2[k] = 1'b0; empty2[k] = 1'b1;
            end
        end
    endtask

    task automatic put4(input int k, input int v, input bit l);
        q4[k].push_back({l, 32'(v)});
    endtask

    task automatic put2(input int k, input int v, input bit l);
        q2[k].push_back({l, 32'(v)});
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) q4[k].delete();
        for (int k = 0; k < 2; k++) q2[k].delete();
        out4_d.delete(); out4_l.delete(); out4_c.delete();
        out2_d.delete(); out2_l.delete(); pop_order2.delete();
        for (int k = 0; k < 4; k++) popcnt4[k] = 0;
    endtask

    // One clock: sample mid-cycle, then apply pops just after the edge
    task automatic step();
        @(negedge clk);
        cyc++;
        p4 = rd4;
        p2 = rd2;
        if (wr4 === 1'b1) begin
            out4_d.push_back(int'(d4)); out4_l.push_back(int'(l4)); out4_c.push_back(cyc);
        end
        if (wr2 === 1'b1) begin
            out2_d.push_back(int'(d2)); out2_l.push_back(int'(l2));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (p4[k]) begin
                popcnt4[k]++;
                n_cmp++;
                if (q4[k].size() == 0) begin
                    n_err++; $error("FAIL leaf4_overread: observed 0 expected 1");
                end else begin
                    void'(q4[k].pop_front());
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (p2[k]) begin
                pop_order2.push_back(k);
                n_cmp++;
                if (q2[k].size() == 0) begin
                    n_err++; $error("FAIL leaf2_overread: observed 0 expected 1");
                end else begin
                    void'(q2[k].pop_front());
                end
            end
        end
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_d[4];
        int exp_l[4];
        int s1, rel, pc;
        rst_n = 1'b0;
        ready = 1'b1;
        p4 = '0;
        p2 = '0;
        cyc = 0;
        flush();
        drive();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (wr4 !== 1'b0) begin n_err++; $error("FAIL rst_wr4: observed %0d expected 0", wr4); end
        n_cmp++; if (d4 !== 32'd0) begin n_err++; $error("FAIL rst_data4: observed %0d expected 0", d4); end
        n_cmp++; if (l4 !== 1'b0) begin n_err++; $error("FAIL rst_last4: observed %0d expected 0", l4); end
        n_cmp++; if (rd4 !== 4'b0000) begin n_err++; $error("FAIL rst_read4: observed %0d expected 0", rd4); end
        n_cmp++; if (wr2 !== 1'b0) begin n_err++; $error("FAIL rst_wr2: observed %0d expected 0", wr2); end
        rst_n = 1'b1;
        step();
        step();

`ifdef MERGE_TREE_DESCENDING_EN
        // Descending order: {8,4},{7,3} -> 8,7,4,3(last)
        put2(0, 8, 0); put2(0, 4, 1);
        put2(1, 7, 0); put2(1, 3, 1);
        drive();
        repeat (8) step();
        exp_d = '{8, 7, 4, 3};
        exp_l = '{0, 0, 0, 1};
        n_cmp++; if (out2_d.size() !== 4) begin n_err++; $error("FAIL desc_count: observed %0d expected 4", out2_d.size()); end
        for (int i = 0; i < out2_d.size() && i < 4; i++) begin
            n_cmp++; if (out2_d[i] !== exp_d[i]) begin n_err++; $error("FAIL desc_data: observed %0d expected %0d", out2_d[i], exp_d[i]); end
            n_cmp++; if (out2_l[i] !== exp_l[i]) begin n_err++; $error("FAIL desc_last: observed %0d expected %0d", out2_l[i], exp_l[i]); end
        end
`else
        // Basic 4-leaf merge and latency
        for (int k = 0; k < 4; k++) begin
            put4(k, k + 1, 0);
            put4(k, k + 5, 1);
        end
        drive();
        cyc = -1;
        repeat (14) step();
        n_cmp++; if (out4_d.size() !== 8) begin n_err++; $error("FAIL t1_count: observed %0d expected 8", out4_d.size()); end
        for (int i = 0; i < out4_d.size() && i < 8; i++) begin
            n_cmp++; if (out4_d[i] !== i + 1) begin n_err++; $error("FAIL t1_data: observed %0d expected %0d", out4_d[i], i + 1); end
            n_cmp++; if (out4_l[i] !== ((i == 7) ? 1 : 0)) begin n_err++; $error("FAIL t1_last: observed %0d expected %0d", out4_l[i], (i == 7) ? 1 : 0); end
            n_cmp++; if (out4_c[i] !== 2 + i) begin n_err++; $error("FAIL t1_cycle: observed %0d expected %0d", out4_c[i], 2 + i); end
        end

        // Tie goes to leaf 0
        flush();
        put2(0, 9, 1);
        put2(1, 9, 1);
        drive();
        repeat (6) step();
        n_cmp++; if (out2_d.size() !== 2) begin n_err++; $error("FAIL tie_count: observed %0d expected 2", out2_d.size()); end
        n_cmp++; if (pop_order2.size() !== 2) begin n_err++; $error("FAIL tie_pops: observed %0d expected 2", pop_order2.size()); end
        if (pop_order2.size() == 2) begin
            n_cmp++; if (pop_order2[0] !== 0) begin n_err++; $error("FAIL tie_first_pop: observed %0d expected 0", pop_order2[0]); end
            n_cmp++; if (pop_order2[1] !== 1) begin n_err++; $error("FAIL tie_second_pop: observed %0d expected 1", pop_order2[1]); end
        end
        for (int i = 0; i < out2_d.size() && i < 2; i++) begin
            n_cmp++; if (out2_d[i] !== 9) begin n_err++; $error("FAIL tie_data: observed %0d expected 9", out2_d[i]); end
            n_cmp++; if (out2_l[i] !== i) begin n_err++; $error("FAIL tie_last: observed %0d expected %0d", out2_l[i], i); end
        end

        // Back-to-back runs without flush
        flush();
        put2(0, 2, 1); put2(0, 1, 1);
        put2(1, 3, 1); put2(1, 0, 1);
        drive();
        repeat (8) step();
        exp_d = '{2, 3, 0, 1};
        exp_l = '{0, 1, 0, 1};
        n_cmp++; if (out2_d.size() !== 4) begin n_err++; $error("FAIL b2b_count: observed %0d expected 4", out2_d.size()); end
        for (int i = 0; i < out2_d.size() && i < 4; i++) begin
            n_cmp++; if (out2_d[i] !== exp_d[i]) begin n_err++; $error("FAIL b2b_data: observed %0d expected %0d", out2_d[i], exp_d[i]); end
            n_cmp++; if (out2_l[i] !== exp_l[i]) begin n_err++; $error("FAIL b2b_last: observed %0d expected %0d", out2_l[i], exp_l[i]); end
        end

        // Back-pressure: 10-cycle stall mid-stream
        flush();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) put4(k, k + 4 * i, (i == 7));
        end
        drive();
        for (int t = 0; t < 20 && out4_d.size() < 4; t++) step();
        n_cmp++; if (out4_d.size() < 4) begin n_err++; $error("FAIL bp_started: observed %0d expected >=4", out4_d.size()); end
        ready = 1'b0;
        step();
        s1 = out4_d.size();
        repeat (6) step();
        pc = popcnt4[0] + popcnt4[1] + popcnt4[2] + popcnt4[3];
        repeat (3) step();
        n_cmp++; if (out4_d.size() !== s1) begin n_err++; $error("FAIL bp_no_write: observed %0d expected %0d", out4_d.size(), s1); end
        n_cmp++; if (popcnt4[0] + popcnt4[1] + popcnt4[2] + popcnt4[3] !== pc) begin n_err++; $error("FAIL bp_leaf_hold: observed %0d expected %0d", popcnt4[0] + popcnt4[1] + popcnt4[2] + popcnt4[3], pc); end
        n_cmp++; if (3'(u4.wptr_q[2] - u4.rptr_q[2]) !== 3'd4) begin n_err++; $error("FAIL bp_fifo2_full: observed %0d expected 4", 3'(u4.wptr_q[2] - u4.rptr_q[2])); end
        n_cmp++; if (3'(u4.wptr_q[3] - u4.rptr_q[3]) !== 3'd4) begin n_err++; $error("FAIL bp_fifo3_full: observed %0d expected 4", 3'(u4.wptr_q[3] - u4.rptr_q[3])); end
        ready = 1'b1;
        rel = out4_d.size();
        repeat (40) step();
        n_cmp++; if (out4_d.size() !== 32) begin n_err++; $error("FAIL bp_count: observed %0d expected 32", out4_d.size()); end
        for (int i = 0; i < out4_d.size() && i < 32; i++) begin
            n_cmp++; if (out4_d[i] !== i) begin n_err++; $error("FAIL bp_data: observed %0d expected %0d", out4_d[i], i); end
            n_cmp++; if (out4_l[i] !== ((i == 31) ? 1 : 0)) begin n_err++; $error("FAIL bp_last: observed %0d expected %0d", out4_l[i], (i == 31) ? 1 : 0); end
        end
        if (out4_d.size() == 32) begin
            n_cmp++; if (out4_c[31] - out4_c[rel] !== 31 - rel) begin n_err++; $error("FAIL bp_stream_rate: observed %0d expected %0d", out4_c[31] - out4_c[rel], 31 - rel); end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (popcnt4[k] !== 8) begin n_err++; $error("FAIL bp_leaf_reads: observed %0d expected 8", popcnt4[k]); end
        end

        // Asynchronous reset mid-run, then a fresh run
        flush();
        for (int i = 0; i < 8; i++) begin
            put2(0, 2 * i, (i == 7));
            put2(1, 2 * i + 1, (i == 7));
        end
        drive();
        for (int t = 0; t < 20 && out2_d.size() < 3; t++) step();
        n_cmp++; if (out2_d.size() < 3) begin n_err++; $error("FAIL ar_started: observed %0d expected >=3", out2_d.size()); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (wr2 !== 1'b0) begin n_err++; $error("FAIL ar_wr_clear: observed %0d expected 0", wr2); end
        n_cmp++; if (d2 !== 32'd0) begin n_err++; $error("FAIL ar_data_clear: observed %0d expected 0", d2); end
        n_cmp++; if (l2 !== 1'b0) begin n_err++; $error("FAIL ar_last_clear: observed %0d expected 0", l2); end
        n_cmp++; if (rd2 !== 2'b00) begin n_err++; $error("FAIL ar_read2_low: observed %0d expected 0", rd2); end
        n_cmp++; if (rd4 !== 4'b0000) begin n_err++; $error("FAIL ar_read4_low: observed %0d expected 0", rd4); end
        flush();
        put2(0, 5, 1);
        put2(1, 6, 1);
        drive();
        step();
        n_cmp++; if (p2 !== 2'b00) begin n_err++; $error("FAIL ar_read_held: observed %0d expected 0", p2); end
        step();
        n_cmp++; if (pop_order2.size() !== 0) begin n_err++; $error("FAIL ar_no_pop: observed %0d expected 0", pop_order2.size()); end
        rst_n = 1'b1;
        flush();
        put2(0, 10, 1);
        put2(1, 11, 1);
        drive();
        repeat (6) step();
        n_cmp++; if (out2_d.size() !== 2) begin n_err++; $error("FAIL ar_fresh_count: observed %0d expected 2", out2_d.size()); end
        for (int i = 0; i < out2_d.size() && i < 2; i++) begin
            n_cmp++; if (out2_d[i] !== 10 + i) begin n_err++; $error("FAIL ar_fresh_data: observed %0d expected %0d", out2_d[i], 10 + i); end
            n_cmp++; if (out2_l[i] !== i) begin n_err++; $error("FAIL ar_fresh_last: observed %0d expected %0d", out2_l[i], i); end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
